systolic_result_drain: RTL and testbench
========================================

# systolic_result_drain

Output-side companion to the systolic matrix multiplier. It captures the full N×N accumulator array from the MAC grid in one cycle once a multiplication has finished. It then requantizes each accumulator to the operand width with an arithmetic right shift and signed saturation, and streams the elements out in row-major order over a valid/ready interface. It sits between the MAC manager's accumulator outputs and whatever consumes result matrices, such as a writeback buffer or the next layer's operand loader.

## Interface
- N, 2, matrix dimension; 1 ≤ N ≤ 256
- ACC_WIDTH, 32, accumulator width per element (signed)
- OUT_WIDTH, 8, output element width (signed); OUT_WIDTH ≤ ACC_WIDTH
- SHIFT, 0, arithmetic right-shift applied before saturation; 0 ≤ SHIFT < ACC_WIDTH

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- acc_in  in  N*N*ACC_WIDTH  accumulator array; element (i,j) at bits ACC_WIDTH*(i*N+j) +: ACC_WIDTH
- acc_valid  in  1  acc_in holds a finished result
- acc_ready  out  1  block can capture; high only in IDLE
- out_data  out  OUT_WIDTH  requantized element
- out_valid  out  1  out_data/out_row/out_col/out_last valid
- out_ready  in  1  consumer accepts current element
- out_row  out  8  row index i of current element
- out_col  out  8  column index j of current element
- out_last  out  1  current element is (N-1,N-1)
- saturated  out  1  sticky: some element of the current matrix has saturated so far
- busy  out  1  high in STREAM

## Operation
- States: IDLE, STREAM.
- IDLE:
  - acc_ready=1, out_valid=0.
  - On acc_valid && acc_ready: latch acc_in into an internal buffer, set index to (0,0), load out_data with element (0,0), clear saturated, then go to STREAM.
- STREAM:
  - acc_ready=0; acc_valid is ignored.
  - out_valid=1. Beat transfers on out_valid && out_ready.
  - On a transfer of a non-last element: index advances row-major (col+1; at col=N-1, col←0 and row+1). out_data, out_row, out_col, and out_last load the next element.
  - On a transfer of the last element: go to IDLE; out_valid drops next cycle.
- Requantize: v = signed(acc) >>> SHIFT (floor toward −∞).
  - If v > 2^(OUT_WIDTH−1)−1, output max.
  - If v < −2^(OUT_WIDTH−1), output min.
  - Otherwise output v[OUT_WIDTH−1:0].
- saturated:
  - Sets in the cycle an element that clips is loaded onto out_data.
  - Stays set until the next capture or reset.
- Boundary conditions:
  - N=1: out_last=1 on the first and only beat.
  - Backpressure (out_ready=0): all outputs hold stable indefinitely.
  - acc_valid during STREAM: no effect; the buffer is not overwritten.
  - Reset asserted mid-stream: returns to IDLE asynchronously; the partial matrix is discarded.

## Timing
- Reset values:
  - state=IDLE, acc_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, saturated=0, busy=0.
  - Buffer contents are don't-care.
- Capture-to-first-beat latency: 1 cycle. The capture edge at cycle t gives out_valid=1 at t+1.
- With out_ready held high, one element per cycle: N² beats over cycles t+1 … t+N².
- After the last transfer at edge t', the block is in IDLE with acc_ready=1 at t'+1. There is no same-cycle bypass, so the minimum period between captures is N²+1 cycles.
- All outputs are registered. No combinational path from out_ready or acc_valid to any output.

## Structure
- Shared package tpu_pkg:
  - MAX_N=256 and LOG2_MAX_N=8 (index widths).
  - Drain state encoding.
- Sub-module acc_requantize (ACC_WIDTH, OUT_WIDTH, SHIFT):
  - Combinational shift + saturate.
  - Outputs the value and a clip flag.
  - Reused later by other result paths.
- Top module holds the buffer, index counter, FSM, and output registers. Expected RTL size: 150–250 lines.

## Test plan
- N=2, SHIFT=0, OUT_WIDTH=8, acc={5,−3,300,−200}, out_ready=1 → beats 0x05, 0xFD, 0x7F, 0x80. Beat (1,0) is 0x7F (300 saturates) and beat (1,1) is 0x80 (−200 saturates). saturated rises with (1,0). out_last only on (1,1). acc_ready returns one cycle after the last beat.
- SHIFT=2, acc={13,−13,−1,4} → outputs 3, −4, −1, 1; saturated stays 0.
- Backpressure: toggle out_ready 1,0,0,1,0,1,… → every element appears exactly once, in order, with outputs stable while stalled.
- acc_valid held high throughout STREAM with acc_in changing → streamed values come from the captured matrix only. The second matrix is captured on the first IDLE cycle.
- N=1, acc={−129} → a single beat 0x80 with out_last=1 and saturated=1.
- reset driven low for 1 cycle after beat 1 of a 2×2 stream → all outputs at reset values immediately. A subsequent capture streams from (0,0) with saturated cleared.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array datapath: index widths and the
// result-drain state encoding.
package tpu_pkg;

  localparam int MAX_N      = 256;
  localparam int LOG2_MAX_N = 8;

  typedef enum logic {
    DRAIN_IDLE   = 1'b0,
    DRAIN_STREAM = 1'b1
  } drain_state_t;

endpackage

// File: rtl/acc_requantize.sv
// Combinational requantizer: arithmetic right shift of a signed accumulator
// followed by signed saturation to OUT_WIDTH. The clip flag marks elements
// that hit either rail.
module acc_requantize #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 0
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [OUT_WIDTH-1:0] value,
  output logic                 clip
);

  // Largest and smallest representable output, sign-extended to accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_WIDTH-1:0] shifted;

  // Shift toward minus infinity, then clamp to the output range.
  always_comb begin
    shifted = $signed(acc) >>> SHIFT;
    value   = shifted[OUT_WIDTH-1:0];
    clip    = 1'b0;
    if (shifted > MAX_V) begin
      value = MAX_V[OUT_WIDTH-1:0];
      clip  = 1'b1;
    end else if (shifted < MIN_V) begin
      value = MIN_V[OUT_WIDTH-1:0];
      clip  = 1'b1;
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures the N x N accumulator array in one cycle, then streams the
// requantized elements in row-major order over valid/ready.
//
//   state        | meaning
//   DRAIN_IDLE   | acc_ready high, waiting for a finished result
//   DRAIN_STREAM | buffer holds a matrix, out_valid high, one beat per handshake
//
// The element after the current one is requantized combinationally so the
// output registers can load it on the same edge the current beat transfers.
module systolic_result_drain
  import tpu_pkg::*;
#(
  parameter int N         = 2,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N*N*ACC_WIDTH-1:0]  acc_in,
  input  logic                      acc_valid,
  output logic                      acc_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LOG2_MAX_N-1:0]     out_row,
  output logic [LOG2_MAX_N-1:0]     out_col,
  output logic                      out_last,
  output logic                      saturated,
  output logic                      busy
);

  localparam int NE = N * N;
  localparam int EW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [EW-1:0]         LAST_IDX = EW'(NE - 1);
  localparam logic [LOG2_MAX_N-1:0] LAST_COL = LOG2_MAX_N'(N - 1);

  drain_state_t         state;
  logic [ACC_WIDTH-1:0] buf_q [NE];
  logic [EW-1:0]        elem_q;
  logic [EW-1:0]        elem_nxt;
  logic [ACC_WIDTH-1:0] next_acc;
  logic [ACC_WIDTH-1:0] sel_acc;
  logic [OUT_WIDTH-1:0] rq_value;
  logic                 rq_clip;

  assign elem_nxt = elem_q + 1'b1;

  // A single-element matrix never advances, so there is no successor to fetch.
  if (NE > 1) begin : g_next
    assign next_acc = buf_q[elem_nxt];
  end else begin : g_next_one
    assign next_acc = buf_q[0];
  end

  // Element (0,0) comes straight from acc_in at capture; afterwards the buffered successor.
  always_comb begin
    sel_acc = (state == DRAIN_IDLE) ? acc_in[ACC_WIDTH-1:0] : next_acc;
  end

  acc_requantize #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_requantize (
    .acc   (sel_acc),
    .value (rq_value),
    .clip  (rq_clip)
  );

  // Buffer is only loaded at capture; contents out of reset are don't-care.
  for (genvar k = 0; k < NE; k++) begin : g_buf
    always_ff @(posedge clk) begin
      if ((state == DRAIN_IDLE) && acc_valid) begin
        buf_q[k] <= acc_in[ACC_WIDTH*k +: ACC_WIDTH];
      end
    end
  end

  // Drain FSM with registered handshake, index and data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DRAIN_IDLE;
      acc_ready <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      saturated <= 1'b0;
      elem_q    <= '0;
    end else begin
      case (state)
        DRAIN_IDLE: begin
          if (acc_valid) begin
            state     <= DRAIN_STREAM;
            acc_ready <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            elem_q    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= (NE == 1);
            out_data  <= rq_value;
            saturated <= rq_clip;
          end
        end
        DRAIN_STREAM: begin
          if (out_ready) begin
            if (elem_q == LAST_IDX) begin
              state     <= DRAIN_IDLE;
              acc_ready <= 1'b1;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end else begin
              elem_q    <= elem_nxt;
              out_data  <= rq_value;
              saturated <= saturated | rq_clip;
              out_last  <= (elem_nxt == LAST_IDX);
              if (out_col == LAST_COL) begin
                out_col <= '0;
                out_row <= out_row + 1'b1;
              end else begin
                out_col <= out_col + 1'b1;
              end
            end
          end
        end
        default: state <= DRAIN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Three drains side by side: 2x2 unshifted, 2x2 with SHIFT=2, and 1x1.
// A matrix-level reference model predicts every output each cycle.
module tb_systolic_result_drain;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int   acc_v [3][4];
  logic av [3];
  logic ordy [3];

  logic [127:0] acc_in_a, acc_in_b;
  logic [31:0]  acc_in_c;
  logic         o_ready [3];
  logic         o_valid [3];
  logic         o_last  [3];
  logic         o_sat   [3];
  logic         o_busy  [3];
  logic [7:0]   o_data  [3];
  logic [7:0]   o_row   [3];
  logic [7:0]   o_col   [3];

  assign acc_in_a = {acc_v[0][3], acc_v[0][2], acc_v[0][1], acc_v[0][0]};
  assign acc_in_b = {acc_v[1][3], acc_v[1][2], acc_v[1][1], acc_v[1][0]};
  assign acc_in_c = acc_v[2][0];

  systolic_result_drain #(.N(2), .ACC_WIDTH(32), .OUT_WIDTH(8), .SHIFT(0)) u_dut_a (
    .clk(clk), .reset(reset), .acc_in(acc_in_a), .acc_valid(av[0]), .acc_ready(o_ready[0]),
    .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(ordy[0]), .out_row(o_row[0]),
    .out_col(o_col[0]), .out_last(o_last[0]), .saturated(o_sat[0]), .busy(o_busy[0]));

  systolic_result_drain #(.N(2), .ACC_WIDTH(32), .OUT_WIDTH(8), .SHIFT(2)) u_dut_b (
    .clk(clk), .reset(reset), .acc_in(acc_in_b), .acc_valid(av[1]), .acc_ready(o_ready[1]),
    .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(ordy[1]), .out_row(o_row[1]),
    .out_col(o_col[1]), .out_last(o_last[1]), .saturated(o_sat[1]), .busy(o_busy[1]));

  systolic_result_drain #(.N(1), .ACC_WIDTH(32), .OUT_WIDTH(8), .SHIFT(0)) u_dut_c (
    .clk(clk), .reset(reset), .acc_in(acc_in_c), .acc_valid(av[2]), .acc_ready(o_ready[2]),
    .out_data(o_data[2]), .out_valid(o_valid[2]), .out_ready(ordy[2]), .out_row(o_row[2]),
    .out_col(o_col[2]), .out_last(o_last[2]), .saturated(o_sat[2]), .busy(o_busy[2]));

  // Reference model: per drain, the requantized matrix and the position of the visible beat.
  int n_of  [3] = '{2, 2, 1};
  int sh_of [3] = '{0, 2, 0};
  int ev    [3][4];
  bit ec    [3][4];
  int cur   [3];
  bit act   [3];
  bit msat  [3];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void requant(input int a, input int sh, output int v, output bit c);
    longint t;
    t = longint'(a) >>> sh;
    if (t > 127) begin
      v = 127; c = 1'b1;
    end else if (t < -128) begin
      v = -128; c = 1'b1;
    end else begin
      v = int'(t); c = 1'b0;
    end
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      act[d] = 1'b0; cur[d] = 0; msat[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int ne;
      ne = n_of[d] * n_of[d];
      if (!act[d]) begin
        if (av[d]) begin
          for (int k = 0; k < ne; k++) requant(acc_v[d][k], sh_of[d], ev[d][k], ec[d][k]);
          cur[d] = 0; act[d] = 1'b1; msat[d] = ec[d][0];
        end
      end else if (ordy[d]) begin
        if (cur[d] == ne - 1) act[d] = 1'b0;
        else begin
          cur[d]++;
          msat[d] = msat[d] | ec[d][cur[d]];
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      string t;
      int n;
      n = n_of[d];
      t = $sformatf("d%0d", d);
      chk({t, "_valid"}, 32'(o_valid[d]), 32'(act[d]));
      chk({t, "_acc_ready"}, 32'(o_ready[d]), 32'(!act[d]));
      chk({t, "_busy"}, 32'(o_busy[d]), 32'(act[d]));
      chk({t, "_saturated"}, 32'(o_sat[d]), 32'(msat[d]));
      if (act[d]) begin
        chk({t, "_data"}, 32'(o_data[d]), 32'(ev[d][cur[d]] & 255));
        chk({t, "_row"}, 32'(o_row[d]), 32'(cur[d] / n));
        chk({t, "_col"}, 32'(o_col[d]), 32'(cur[d] % n));
        chk({t, "_last"}, 32'(o_last[d]), 32'(cur[d] == n * n - 1));
      end
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      string t;
      t = $sformatf("%s_d%0d", tag, d);
      chk({t, "_valid"}, 32'(o_valid[d]), 32'd0);
      chk({t, "_acc_ready"}, 32'(o_ready[d]), 32'd1);
      chk({t, "_data"}, 32'(o_data[d]), 32'd0);
      chk({t, "_row"}, 32'(o_row[d]), 32'd0);
      chk({t, "_col"}, 32'(o_col[d]), 32'd0);
      chk({t, "_last"}, 32'(o_last[d]), 32'd0);
      chk({t, "_saturated"}, 32'(o_sat[d]), 32'd0);
      chk({t, "_busy"}, 32'(o_busy[d]), 32'd0);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic int rand_acc();
    if ($urandom_range(3) == 0) return int'($urandom);
    return int'($urandom_range(1200)) - 600;
  endfunction

  int exp_a [4] = '{'h05, 'hFD, 'h7F, 'h80};
  int exp_b [4] = '{'h03, 'hFC, 'hFF, 'h01};
  bit pat   [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1};

  initial begin
    for (int d = 0; d < 3; d++) begin
      av[d] = 1'b0; ordy[d] = 1'b1;
      for (int k = 0; k < 4; k++) acc_v[d][k] = 0;
    end
    model_reset();
    #12;
    check_reset("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    check_all();

    // Directed matrices from the test plan on all three drains at once.
    acc_v[0] = '{5, -3, 300, -200};
    acc_v[1] = '{13, -13, -1, 4};
    acc_v[2][0] = -129;
    for (int d = 0; d < 3; d++) av[d] = 1'b1;
    step();
    for (int d = 0; d < 3; d++) av[d] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("plan_a_data", 32'(o_data[0]), 32'(exp_a[b]));
      chk("plan_a_sat", 32'(o_sat[0]), 32'(b >= 2));
      chk("plan_a_last", 32'(o_last[0]), 32'(b == 3));
      chk("plan_b_data", 32'(o_data[1]), 32'(exp_b[b]));
      chk("plan_b_sat", 32'(o_sat[1]), 32'd0);
      if (b == 0) begin
        chk("plan_c_data", 32'(o_data[2]), 32'h80);
        chk("plan_c_last", 32'(o_last[2]), 32'd1);
        chk("plan_c_sat", 32'(o_sat[2]), 32'd1);
      end
      step();
    end
    chk("plan_a_ready_after_last", 32'(o_ready[0]), 32'd1);

    // Backpressure pattern on the first drain.
    acc_v[0] = '{-1000, 77, -77, 1000};
    av[0] = 1'b1;
    step();
    av[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ordy[0] = pat[i];
      step();
    end
    ordy[0] = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // acc_valid held high with acc_in changing every cycle.
    av[0] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 4; k++) acc_v[0][k] = rand_acc();
      step();
    end
    av[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Asynchronous reset after beat 1 of a saturating stream, then a clean recapture.
    acc_v[0] = '{300, 1, 2, 3};
    av[0] = 1'b1;
    step();
    av[0] = 1'b0;
    step();
    reset = 1'b0;
    #2;
    check_reset("midreset");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    check_reset("midreset_hold");
    acc_v[0] = '{1, 2, 3, 4};
    av[0] = 1'b1;
    step();
    av[0] = 1'b0;
    chk("recap_row", 32'(o_row[0]), 32'd0);
    chk("recap_col", 32'(o_col[0]), 32'd0);
    chk("recap_sat", 32'(o_sat[0]), 32'd0);
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic on all drains.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        ordy[d] = ($urandom_range(99) < 65);
        av[d]   = ($urandom_range(99) < 30);
        for (int k = 0; k < 4; k++) acc_v[d][k] = rand_acc();
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
